// File: rtl/start_light_seq.sv
// Race-start light sequencer: steps N_LIGHTS lights on millisecond ticks, holds, then times the react press.
// Optional feature macro: START_LIGHT_RANDOM_HOLD_EN (LFSR-randomised hold extension).
module start_light_seq #(
    parameter int N_LIGHTS    = 5,
    parameter int STEP_MS     = 1000,
    parameter int HOLD_MIN_MS = 200,
    parameter int HOLD_RAND_W = 10,
    parameter int TIME_W      = 14,
    parameter int MAX_MS      = 9999
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_tick,
    input  logic                i_start,
    input  logic                i_react,
    output logic [N_LIGHTS-1:0] o_lights,
    output logic [TIME_W-1:0]   o_timeMs,
    output logic                o_valid,
    output logic                o_falseStart,
    output logic                o_busy
);

    localparam int HOLD_MAX = HOLD_MIN_MS + (1 << HOLD_RAND_W) - 1;
    localparam int CNT_MAX  = (STEP_MS > HOLD_MAX) ? STEP_MS : HOLD_MAX;
    localparam int CNT_W0   = $clog2(CNT_MAX + 1);
    // The same counter also times the GO phase, so it must cover TIME_W too.
    localparam int CNT_W    = (CNT_W0 > TIME_W) ? CNT_W0 : TIME_W;

    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, DONE, FAULT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_target;
    logic [CNT_W-1:0] hold_next;

`ifdef START_LIGHT_RANDOM_HOLD_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        hold_next = CNT_W'(HOLD_MIN_MS) + CNT_W'(lfsr[HOLD_RAND_W-1:0]);
    end
`else
    always_comb begin
        hold_next = CNT_W'(HOLD_MIN_MS);
    end
`endif

    always_comb begin
        o_busy = (state == LIGHTS) || (state == HOLD) || (state == GO);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state        <= IDLE;
            cnt          <= '0;
            hold_target  <= '0;
            o_lights     <= '0;
            o_timeMs     <= '0;
            o_valid      <= 1'b0;
            o_falseStart <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FAULT: begin
                    if (i_start) begin
                        state        <= LIGHTS;
                        o_lights     <= N_LIGHTS'(1);
                        o_valid      <= 1'b0;
                        o_falseStart <= 1'b0;
                        cnt          <= '0;
                    end
                end
                LIGHTS: begin
                    if (i_react) begin
                        state        <= FAULT;
                        o_falseStart <= 1'b1;
                        o_valid      <= 1'b0;
                    end else if (i_tick) begin
                        if (cnt == CNT_W'(STEP_MS - 1)) begin
                            o_lights <= {o_lights[N_LIGHTS-2:0], 1'b1};
                            cnt      <= '0;
                            // Shifting sets the top light exactly when the one below it is lit now.
                            if (o_lights[N_LIGHTS-2]) begin
                                state       <= HOLD;
                                hold_target <= hold_next;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_react) begin
                        state        <= FAULT;
                        o_falseStart <= 1'b1;
                        o_valid      <= 1'b0;
                    end else if (i_tick) begin
                        if (cnt == hold_target - 1'b1) begin
                            state    <= GO;
                            o_lights <= '0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GO: begin
                    if (i_react) begin
                        state    <= DONE;
                        o_timeMs <= cnt[TIME_W-1:0];
                        o_valid  <= 1'b1;
                    end else if (i_tick && (cnt < CNT_W'(MAX_MS))) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
